// File: rtl/axi_lite_rom_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_rom_slave
//  Function : AXI4-Lite slave serving read-only 32-bit words from a
//             synchronous block ROM. In-window reads return OKAY with ROM
//             data, out-of-window reads return DECERR, every write returns
//             SLVERR. One outstanding transaction per direction; the read
//             and write channels are fully independent.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_rom_slave #(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_ROM_ADDR_WIDTH   = 10,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = '0
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // write response channel
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    // block ROM port
    output logic                            ROM_EN,
    output logic [C_ROM_ADDR_WIDTH-1:0]     ROM_ADDR,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   ROM_DATA
);

    // Lowest address bit that selects the window (above the word index).
    localparam int c_SEL_LSB = C_ROM_ADDR_WIDTH + 2;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // Read FSM encoding
    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_ROM  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RD_RESP = 2'd3;

    // ------------------------------------------------------------------------
    // Common: "live" flag keeps every ready low while reset is applied and
    // for the reset edge itself; readies appear once reset has been released.
    // ------------------------------------------------------------------------
    logic live_q;

    // Track whether the block has left reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    logic [1:0]                    rd_state_q, rd_state_d;
    logic                          hit_q,      hit_d;
    logic                          rom_en_q,   rom_en_d;
    logic [C_ROM_ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic                          rvalid_q,   rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic [1:0]                    rresp_q,    rresp_d;

    logic w_arready;
    logic w_ar_hs;
    logic w_hit;

    assign w_arready = live_q && (rd_state_q == RD_IDLE);
    assign w_ar_hs   = S_AXI_ARVALID && w_arready;

    // Window decode: the bits above the ROM word index must match the base.
    generate
        if (c_SEL_LSB < C_S_AXI_ADDR_WIDTH) begin : g_window_decode
            assign w_hit = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:c_SEL_LSB]
                            == C_BASEADDR[C_S_AXI_ADDR_WIDTH-1:c_SEL_LSB]);
        end else begin : g_full_window
            assign w_hit = 1'b1;
        end
    endgenerate

    // Read FSM state register plus the registered read-path outputs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state_q <= RD_IDLE;
            hit_q      <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= c_RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            hit_q      <= hit_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Read FSM next-state: fixed IDLE->ROM->WAIT walk, then hold in RESP.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (w_ar_hs)      rd_state_d = RD_ROM;
            RD_ROM:                    rd_state_d = RD_WAIT;
            RD_WAIT:                   rd_state_d = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) rd_state_d = RD_IDLE;
            default:                   rd_state_d = RD_IDLE;
        endcase
    end

    // Read FSM outputs: launch the ROM read, capture its data, present R.
    always_comb begin
        hit_d      = hit_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    // Misses still walk the same states so latency matches,
                    // but never touch the ROM.
                    hit_d      = w_hit;
                    rom_addr_d = S_AXI_ARADDR[c_SEL_LSB-1:2];
                    rom_en_d   = w_hit;
                end
            end
            RD_WAIT: begin
                rdata_d  = hit_q ? ROM_DATA : '0;
                rresp_d  = hit_q ? c_RESP_OKAY : c_RESP_DECERR;
                rvalid_d = 1'b1;
            end
            RD_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                rom_en_d = 1'b0;
            end
        endcase
    end

    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign ROM_EN        = rom_en_q;
    assign ROM_ADDR      = rom_addr_q;

    // ------------------------------------------------------------------------
    // Write path: accept AW and W independently, answer SLVERR once both
    // have arrived. Nothing further is accepted until B completes.
    // ------------------------------------------------------------------------
    logic aw_done_q, aw_done_d;
    logic w_done_q,  w_done_d;
    logic bvalid_q,  bvalid_d;

    logic w_awready;
    logic w_wready;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;

    assign w_awready = live_q && !aw_done_q && !bvalid_q;
    assign w_wready  = live_q && !w_done_q  && !bvalid_q;
    assign w_aw_hs   = S_AXI_AWVALID && w_awready;
    assign w_w_hs    = S_AXI_WVALID  && w_wready;
    assign w_b_hs    = bvalid_q && S_AXI_BREADY;

    // Write-channel next state: flags clear together with the B handshake.
    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bvalid_d  = bvalid_q;
        if (w_b_hs) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            bvalid_d  = 1'b0;
        end else begin
            if (w_aw_hs) aw_done_d = 1'b1;
            if (w_w_hs)  w_done_d  = 1'b1;
            // Response is raised from the registered flags, i.e. one edge
            // after the later of the two handshakes.
            if (aw_done_q && w_done_q) bvalid_d = 1'b1;
        end
    end

    // Write-channel registers.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bvalid_q  <= bvalid_d;
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = c_RESP_SLVERR;

    // Inputs that carry no meaning for a read-only word-addressed slave.
    logic w_unused;
    assign w_unused = ^{S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_WDATA, S_AXI_WSTRB,
                        S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rom_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_rom_slave
//  Function : Scoreboard bench for axi_lite_rom_slave (default parameters,
//             base 0, 1024-word ROM).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_rom_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [1:0]  BRESP, RRESP;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] RDATA;
    logic        ROM_EN;
    logic [9:0]  ROM_ADDR;
    logic [31:0] rom_data;

    always #5 clk = ~clk;

    axi_lite_rom_slave dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (AWADDR),
        .S_AXI_AWPROT (AWPROT),
        .S_AXI_AWVALID(AWVALID),
        .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA  (WDATA),
        .S_AXI_WSTRB  (WSTRB),
        .S_AXI_WVALID (WVALID),
        .S_AXI_WREADY (WREADY),
        .S_AXI_BRESP  (BRESP),
        .S_AXI_BVALID (BVALID),
        .S_AXI_BREADY (BREADY),
        .S_AXI_ARADDR (ARADDR),
        .S_AXI_ARPROT (ARPROT),
        .S_AXI_ARVALID(ARVALID),
        .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA  (RDATA),
        .S_AXI_RRESP  (RRESP),
        .S_AXI_RVALID (RVALID),
        .S_AXI_RREADY (RREADY),
        .ROM_EN       (ROM_EN),
        .ROM_ADDR     (ROM_ADDR),
        .ROM_DATA     (rom_data)
    );

    // Synchronous ROM: data appears the cycle after ROM_EN is sampled.
    logic [31:0] mem [0:1023];
    always @(posedge clk) if (ROM_EN) rom_data <= mem[ROM_ADDR];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got none expected event (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model and scoreboard queues ----------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];

    // Window is bytes 0..4095; everything else decodes to DECERR.
    function automatic rexp_t model_read(input logic [31:0] a);
        rexp_t r;
        if (a < 32'h1000) begin
            r.data = mem[a[11:2]];
            r.resp = 2'b00;
        end else begin
            r.data = 32'h0;
            r.resp = 2'b11;
        end
        return r;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic do_read(input logic [31:0] a, input int d);
        int t;
        rq.push_back(model_read(a));
        ARADDR  = a;
        ARVALID = 1'b1;
        RREADY  = (d == 0);
        t = 0;
        while (!ARREADY && t < 50) begin @(posedge clk); #1; t++; end
        if (!ARREADY) begin
            fail_now("ar_timeout");
            ARVALID = 1'b0;
            RREADY  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ARVALID = 1'b0;
        t = 0;
        while (!RVALID && t < 50) begin @(posedge clk); #1; t++; end
        if (!RVALID) begin
            fail_now("r_timeout");
            RREADY = 1'b0;
            return;
        end
        if (d > 0) begin
            repeat (d) begin @(posedge clk); #1; end
            RREADY = 1'b1;
        end
        @(posedge clk); #1;
        RREADY = 1'b0;
    endtask

    task automatic do_write(input int ad, input int wd, input int bd);
        int t;
        bq.push_back(2'b10);
        fork
            begin
                int ta;
                repeat (ad) begin @(posedge clk); #1; end
                AWADDR  = $urandom;
                AWVALID = 1'b1;
                ta = 0;
                while (!AWREADY && ta < 50) begin @(posedge clk); #1; ta++; end
                if (!AWREADY) fail_now("aw_timeout");
                else begin @(posedge clk); #1; end
                AWVALID = 1'b0;
            end
            begin
                int tw;
                repeat (wd) begin @(posedge clk); #1; end
                WDATA  = $urandom;
                WVALID = 1'b1;
                tw = 0;
                while (!WREADY && tw < 50) begin @(posedge clk); #1; tw++; end
                if (!WREADY) fail_now("w_timeout");
                else begin @(posedge clk); #1; end
                WVALID = 1'b0;
            end
        join
        t = 0;
        while (!BVALID && t < 50) begin @(posedge clk); #1; t++; end
        if (!BVALID) begin
            fail_now("b_timeout");
            return;
        end
        repeat (bd) begin @(posedge clk); #1; end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
    endtask

    // ---------------- monitor ----------------
    int          en_edge = -100, ar_edge = -100, ar_rdy_cyc = -1;
    int          aw_edge = -1, w_edge = -1, b_rdy_cyc = -1;
    logic        en_hit = 1'b0;
    logic [9:0]  en_word = '0;
    logic        exp_en;
    logic        rv_prev = 1'b0, bv_prev = 1'b0;
    logic [31:0] hold_rdata;
    logic [1:0]  hold_rresp;
    rexp_t       e;
    logic [1:0]  eb;
    int          lat;

    // Pops the scoreboard whenever the DUT presents a response and checks
    // channel timing rules relative to the observed handshakes.
    always @(negedge clk) begin
        if (rst) begin
            en_edge = -100; ar_edge = -100; ar_rdy_cyc = -1;
            aw_edge = -1;   w_edge  = -1;   b_rdy_cyc  = -1;
            rv_prev = 1'b0; bv_prev = 1'b0;
        end else begin
            exp_en = (cyc == en_edge) && en_hit;
            check("rom_en", 64'(ROM_EN), 64'(exp_en));
            if (exp_en) check("rom_addr", 64'(ROM_ADDR), 64'(en_word));
            if (ARVALID && ARREADY) begin
                en_edge = cyc + 1;
                ar_edge = cyc + 1;
                en_hit  = (ARADDR < 32'h1000);
                en_word = ARADDR[11:2];
            end
            if (cyc == ar_rdy_cyc) check("arready_after_r", 64'(ARREADY), 64'd1);
            if (RVALID) begin
                if (!rv_prev) begin
                    check("r_latency", 64'(cyc), 64'(ar_edge + 2));
                    if (rq.size() == 0) fail_now("r_unexpected");
                    else begin
                        e = rq.pop_front();
                        check("rdata", 64'(RDATA), 64'(e.data));
                        check("rresp", 64'(RRESP), 64'(e.resp));
                    end
                    hold_rdata = RDATA;
                    hold_rresp = RRESP;
                end else begin
                    check("rdata_stable", 64'(RDATA), 64'(hold_rdata));
                    check("rresp_stable", 64'(RRESP), 64'(hold_rresp));
                end
                check("arready_busy", 64'(ARREADY), 64'd0);
                if (RREADY) ar_rdy_cyc = cyc + 1;
            end
            rv_prev = RVALID && !RREADY;

            if (cyc == b_rdy_cyc) begin
                check("awready_after_b", 64'(AWREADY), 64'd1);
                check("wready_after_b",  64'(WREADY),  64'd1);
            end
            if (BVALID) begin
                if (!bv_prev) begin
                    if (aw_edge < 0 || w_edge < 0) fail_now("b_without_aw_w");
                    else begin
                        lat = (aw_edge > w_edge) ? aw_edge : w_edge;
                        check("b_latency", 64'(cyc), 64'(lat + 1));
                    end
                    aw_edge = -1;
                    w_edge  = -1;
                    if (bq.size() == 0) fail_now("b_unexpected");
                    else begin
                        eb = bq.pop_front();
                        check("bresp", 64'(BRESP), 64'(eb));
                    end
                end else begin
                    check("bresp_stable", 64'(BRESP), 64'h2);
                end
                check("awready_busy", 64'(AWREADY), 64'd0);
                check("wready_busy",  64'(WREADY),  64'd0);
                if (BREADY) b_rdy_cyc = cyc + 1;
            end
            bv_prev = BVALID && !BREADY;
            if (AWVALID && AWREADY) aw_edge = cyc + 1;
            if (WVALID && WREADY)   w_edge  = cyc + 1;
        end
    end

    // ---------------- main sequence ----------------
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[5] = 32'hDEAD_BEEF;
        rst = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0;
        WVALID = 1'b0; BREADY = 1'b0; ARADDR = '0; ARPROT = '0;
        ARVALID = 1'b0; RREADY = 1'b0;

        repeat (3) begin @(posedge clk); #1; end
        check("rst_arready", 64'(ARREADY), 64'd0);
        check("rst_awready", 64'(AWREADY), 64'd0);
        check("rst_wready",  64'(WREADY),  64'd0);
        check("rst_rvalid",  64'(RVALID),  64'd0);
        check("rst_bvalid",  64'(BVALID),  64'd0);
        check("rst_rom_en",  64'(ROM_EN),  64'd0);
        check("rst_rdata",   64'(RDATA),   64'd0);
        check("rst_rresp",   64'(RRESP),   64'd0);
        check("rst_bresp",   64'(BRESP),   64'h2);
        check("rst_rom_addr", 64'(ROM_ADDR), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_arready", 64'(ARREADY), 64'd1);
        check("rel_awready", 64'(AWREADY), 64'd1);
        check("rel_wready",  64'(WREADY),  64'd1);

        fork
            begin
                do_read(32'h14, 0);
                do_read(32'h1000, 0);
                do_read(32'h17, 0);
                do_read(32'h14, 5);
                do_read(32'hFFC, 1);
                for (int i = 0; i < 30; i++) begin
                    case ($urandom_range(0, 3))
                        0, 1: ra = 32'($urandom_range(0, 4095));
                        2: begin
                            ra = $urandom;
                            if (ra < 32'h1000) ra = ra | 32'h8000_0000;
                        end
                        default: ra = 32'hFFC + 32'($urandom_range(0, 7));
                    endcase
                    do_read(ra, int'($urandom_range(0, 4)));
                end
            end
            begin
                do_write(1, 0, 3);
                do_write(0, 0, 0);
                do_write(0, 2, 0);
                for (int j = 0; j < 10; j++)
                    do_write(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 3)));
            end
        join

        // Reset while a read sits in RD_WAIT and a write response is pending.
        BREADY = 1'b0;
        bq.push_back(2'b10);
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_bvalid", 64'(BVALID), 64'd1);
        ARADDR  = 32'h14;
        ARVALID = 1'b1;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rq.delete();
        bq.delete();
        check("mid_rst_rvalid",  64'(RVALID),  64'd0);
        check("mid_rst_bvalid",  64'(BVALID),  64'd0);
        check("mid_rst_rom_en",  64'(ROM_EN),  64'd0);
        check("mid_rst_arready", 64'(ARREADY), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_arready", 64'(ARREADY), 64'd1);
        check("post_rst_awready", 64'(AWREADY), 64'd1);
        check("post_rst_wready",  64'(WREADY),  64'd1);
        check("post_rst_rvalid",  64'(RVALID),  64'd0);

        // One read after recovery to confirm normal service resumes.
        do_read(32'h14, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("sb_read_empty",  64'(rq.size()), 64'd0);
        check("sb_write_empty", 64'(bq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
